// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with clear, clamped load, terminal-count pulse and sticky overflow.
// Define PARAM_UPDOWN_COUNTER_SAT_EN to hold at the end value instead of wrapping on terminal steps.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZeroVal = '0;
  localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);

`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] UpTermVal = MaxVal;
  localparam logic [WIDTH-1:0] DnTermVal = ZeroVal;
`else
  localparam logic [WIDTH-1:0] UpTermVal = ZeroVal;
  localparam logic [WIDTH-1:0] DnTermVal = MaxVal;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             term_step;

  always_comb begin
    count_d   = count_q;
    term_step = 1'b0;
    if (clr_i) begin
      count_d = ZeroVal;
    end else if (load_i) begin
      count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (count_q >= MaxVal) begin
          term_step = 1'b1;
          count_d   = UpTermVal;
        end else begin
          count_d = count_q + OneVal;
        end
      end else begin
        if (count_q == ZeroVal) begin
          term_step = 1'b1;
          count_d   = DnTermVal;
        end else begin
          count_d = count_q - OneVal;
        end
      end
    end
  end

  // A terminal step outranks a simultaneous ovf_clr.
  always_comb begin
    tc_d  = term_step;
    ovf_d = ovf_q;
    if (term_step) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: instance A (WIDTH=4, MAX_COUNT=15) and instance B (WIDTH=4, MAX_COUNT=9).
module tb_param_updown_counter;

`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;
    logic       ovf_clr;
    logic [3:0] count;
    logic       tc;
    logic       ovf;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] count;
    logic       tc;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 0, a_ovf_clr = 0;
  logic [3:0] a_load_val = '0;
  logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 0, b_ovf_clr = 0;
  logic [3:0] b_load_val = '0;
  logic [3:0] a_count, b_count;
  logic       a_tc, a_ovf, b_tc, b_ovf;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b[$];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4)) u_a (
    .clk_i(clk), .rstn_i(rstn), .clr_i(a_clr), .load_i(a_load), .load_val_i(a_load_val),
    .en_i(a_en), .up_i(a_up), .ovf_clr_i(a_ovf_clr),
    .count_o(a_count), .tc_o(a_tc), .ovf_o(a_ovf)
  );

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(9)) u_b (
    .clk_i(clk), .rstn_i(rstn), .clr_i(b_clr), .load_i(b_load), .load_val_i(b_load_val),
    .en_i(b_en), .up_i(b_up), .ovf_clr_i(b_ovf_clr),
    .count_o(b_count), .tc_o(b_tc), .ovf_o(b_ovf)
  );

  function automatic vec_t mk(logic clr, logic load, logic [3:0] val, logic en, logic up,
                              logic oc, logic [3:0] cnt, logic tc, logic ovf);
    vec_t v;
    v.clr = clr; v.load = load; v.load_val = val; v.en = en; v.up = up; v.ovf_clr = oc;
    v.count = cnt; v.tc = tc; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string tag, input logic [3:0] cnt, input logic tc, input logic ovf,
                       input exp_t e);
    total++;
    if (cnt !== e.count || tc !== e.tc || ovf !== e.ovf) begin
      bad++;
      $display("FAIL %s: got count=%0d tc=%0b ovf=%0b, want count=%0d tc=%0b ovf=%0b",
               tag, cnt, tc, ovf, e.count, e.tc, e.ovf);
    end
  endtask

  task automatic idle_inputs();
    a_clr = 0; a_load = 0; a_load_val = '0; a_en = 0; a_up = 0; a_ovf_clr = 0;
    b_clr = 0; b_load = 0; b_load_val = '0; b_en = 0; b_up = 0; b_ovf_clr = 0;
  endtask

  // Drive one vector on the falling edge, sample just after the next rising edge.
  task automatic step(input vec_t v, input bit sel_b, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    idle_inputs();
    if (sel_b) begin
      b_clr = v.clr; b_load = v.load; b_load_val = v.load_val;
      b_en = v.en; b_up = v.up; b_ovf_clr = v.ovf_clr;
    end else begin
      a_clr = v.clr; a_load = v.load; a_load_val = v.load_val;
      a_en = v.en; a_up = v.up; a_ovf_clr = v.ovf_clr;
    end
    e.tag = tag; e.count = v.count; e.tc = v.tc; e.ovf = v.ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (sel_b) check(got.tag, b_count, b_tc, b_ovf, got);
    else       check(got.tag, a_count, a_tc, a_ovf, got);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t z;
    logic [3:0] c;
    z.tag = "reset"; z.count = 4'd0; z.tc = 1'b0; z.ovf = 1'b0;

    // Instance A: free-running up count through the wrap, then priority/load/ovf cases.
    for (int i = 0; i < 18; i++) begin
      if (Sat) c = (i >= 15) ? 4'd15 : 4'(i + 1);
      else     c = 4'((i + 1) % 16);
      tab_a.push_back(mk(0, 0, 0, 1, 1, 0, c, (i == 15) || (Sat && i > 15), i >= 15));
    end
    tab_a.push_back(mk(0, 1, 4'd7, 0, 0, 0, 4'd7, 0, 1));
    tab_a.push_back(mk(1, 1, 4'd5, 1, 1, 0, 4'd0, 0, 1));
    tab_a.push_back(mk(0, 1, 4'd5, 1, 1, 0, 4'd5, 0, 1));
    tab_a.push_back(mk(0, 1, 4'd12, 0, 0, 0, 4'd12, 0, 1));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 1, 4'd12, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 0, 1, 0, 4'd12, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 0, 4'd11, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 1, 1, 0, 4'd12, 0, 0));
    tab_a.push_back(mk(0, 1, 4'd0, 0, 0, 0, 4'd0, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 0, Sat ? 4'd0 : 4'd15, 1, 1));
    tab_a.push_back(mk(0, 1, 4'd0, 0, 0, 0, 4'd0, 0, 1));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 1, Sat ? 4'd0 : 4'd15, 1, 1));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 1, Sat ? 4'd0 : 4'd15, 0, 0));

    // Instance B (MAX_COUNT=9): clamped load, down count through the wrap.
    tab_b.push_back(mk(0, 1, 4'd12, 0, 0, 0, 4'd9, 0, 0));
    for (int i = 0; i < 11; i++) begin
      if (i <= 8)  c = 4'(8 - i);
      else if (Sat) c = 4'd0;
      else         c = (i == 9) ? 4'd9 : 4'd8;
      tab_b.push_back(mk(0, 0, 0, 1, 0, 0, c, (i == 9) || (Sat && i > 9), i >= 9));
    end
    tab_b.push_back(mk(0, 1, 4'd10, 0, 0, 0, 4'd9, 0, 1));
    tab_b.push_back(mk(1, 0, 0, 0, 0, 0, 4'd0, 0, 1));
    tab_b.push_back(mk(0, 0, 0, 1, 1, 0, 4'd1, 0, 1));
    tab_b.push_back(mk(0, 1, 4'd9, 0, 0, 0, 4'd9, 0, 1));
    tab_b.push_back(mk(0, 0, 0, 1, 1, 0, Sat ? 4'd9 : 4'd0, 1, 1));

    // Power-on reset, checked before any clock edge.
    #1 rstn = 1'b0;
    #2;
    check("reset_a", a_count, a_tc, a_ovf, z);
    check("reset_b", b_count, b_tc, b_ovf, z);
    #9 rstn = 1'b1;

    foreach (tab_a[i]) step(tab_a[i], 1'b0, $sformatf("a_vec%0d", i));
    foreach (tab_b[i]) step(tab_b[i], 1'b1, $sformatf("b_vec%0d", i));

    // Asynchronous reset mid-count with ovf and count non-zero.
    step(mk(0, 1, 4'd15, 0, 0, 0, 4'd15, 0, Sat ? 1'b0 : 1'b0), 1'b0, "a_pre_load15");
    step(mk(0, 0, 0, 1, 1, 0, Sat ? 4'd15 : 4'd0, 1, 1), 1'b0, "a_pre_term");
    step(mk(0, 1, 4'd5, 0, 0, 0, 4'd5, 0, 1), 1'b0, "a_pre_load5");
    step(mk(0, 0, 0, 1, 1, 0, 4'd6, 0, 1), 1'b0, "a_pre_six");
    a_en = 1'b1; a_up = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("a_async_reset", a_count, a_tc, a_ovf, z);
    #2 a_en = 1'b0;
    #1 rstn = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 0), 1'b0, "a_post_reset_idle");
    step(mk(0, 0, 0, 1, 1, 0, 4'd1, 0, 0), 1'b0, "a_resume1");
    step(mk(0, 0, 0, 1, 1, 0, 4'd2, 0, 0), 1'b0, "a_resume2");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
